// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 16-entry register-file read port among NREQ
// requesters; the mux output is captured into a registered, ID-tagged response.
module regfile_read_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_addr,
  input  logic              stall,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        sel,
  input  logic [DW-1:0]     mux_out,
  output logic              rd_valid,
  output logic [IDW-1:0]    rd_id,
  output logic [DW-1:0]     rd_data
);

  logic [IDW-1:0] r_ptr;
  logic [3:0]     r_sel_q;
  logic           r_rd_valid;
  logic [IDW-1:0] r_rd_id;
  logic [DW-1:0]  r_rd_data;

  logic [IDW:0]   w_idx;
  logic [IDW-1:0] w_cand;
  logic [IDW-1:0] w_win;
  logic           w_found;
  logic           w_grant;
  logic [IDW-1:0] w_ptr_nxt;

  // Rotating search from r_ptr; the first pending requester wins.
  always_comb begin
    w_idx   = '0;
    w_cand  = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NREQ))
        w_idx = w_idx - (IDW+1)'(NREQ);
      w_cand = w_idx[IDW-1:0];
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_grant   = w_found && !stall && !reset;
    gnt       = '0;
    sel       = r_sel_q;
    w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;
    if (w_grant) begin
      gnt[w_win] = 1'b1;
      sel        = req_addr[{w_win, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      r_sel_q    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_id    <= '0;
      r_rd_data  <= '0;
    end else if (w_grant) begin
      r_ptr      <= w_ptr_nxt;
      r_sel_q    <= sel;
      r_rd_valid <= 1'b1;
      r_rd_id    <= w_win;
      r_rd_data  <= mux_out;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_id    = r_rd_id;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomized and directed bench for regfile_read_arbiter against a
// cycle-level behavioural model of the round-robin read-port sharing.
module tb_regfile_read_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_addr;
  logic              stall;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        sel;
  logic [DW-1:0]     mux_out;
  logic              rd_valid;
  logic [IDW-1:0]    rd_id;
  logic [DW-1:0]     rd_data;

  logic [DW-1:0] regs [16];
  assign mux_out = regs[sel];

  regfile_read_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .stall(stall),
    .gnt(gnt), .sel(sel), .mux_out(mux_out), .rd_valid(rd_valid),
    .rd_id(rd_id), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_ptr;
  logic [3:0]  m_selq;
  logic        m_valid;
  int          m_id;
  logic [DW-1:0] m_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic mreset();
    m_ptr = 0; m_selq = 4'h0; m_valid = 1'b0; m_id = 0; m_data = '0;
  endtask

  function automatic int find_win();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] addr_of(input int i);
    logic [4*NREQ-1:0] a;
    a = req_addr;
    return a[i*4 +: 4];
  endfunction

  // Entered at a negedge with inputs already applied; leaves at the next negedge.
  task automatic step();
    int w;
    logic g;
    logic [NREQ-1:0] eg;
    logic [3:0] es;
    #1;
    if (reset) mreset();
    w  = find_win();
    g  = !reset && !stall && (w >= 0);
    eg = '0;
    es = m_selq;
    if (g) begin
      eg[w] = 1'b1;
      es    = addr_of(w);
    end
    chk("gnt", 64'(gnt), 64'(eg));
    chk("sel", 64'(sel), 64'(es));
    chk("rd_valid", 64'(rd_valid), 64'(m_valid));
    chk("rd_id", 64'(rd_id), 64'(m_id));
    chk("rd_data", 64'(rd_data), 64'(m_data));
    @(posedge clk);
    if (reset) mreset();
    else if (g) begin
      m_ptr   = (w + 1) % NREQ;
      m_valid = 1'b1;
      m_id    = w;
      m_data  = regs[es];
      m_selq  = es;
    end else begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    mreset();
    reset = 1'b1; req = '0; req_addr = '0; stall = 1'b0;
    @(negedge clk);
    step();
    reset = 1'b0;

    // Build up state, then reset mid-run with all requesting.
    req_addr = 16'h4321; req = 4'b1111;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_sel", 64'(sel), 64'h0);
    reset = 1'b0;
    step();
    chk("rst_first_id", 64'(rd_id), 64'h0);

    // Round-robin fairness over eight held cycles.
    for (int i = 1; i <= 4; i++) regs[i] = 32'h1000_0000 + i;
    reset = 1'b1; step(); reset = 1'b0;
    req_addr = 16'h4321; req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rr_id", 64'(rd_id), 64'(c % 4));
      chk("rr_data", 64'(rd_data), 64'(32'h1000_0000 + (c % 4) + 1));
    end

    // Single requester reading register 10.
    regs[10] = 32'hDEADBEEF;
    req = 4'b0100; req_addr = 16'h0A00;
    step();
    chk("single_valid", 64'(rd_valid), 64'h1);
    chk("single_id", 64'(rd_id), 64'h2);
    chk("single_data", 64'(rd_data), 64'hDEADBEEF);

    // Pointer now at 3: wrap to 0, skip 1, then 2, then back to 0.
    req = 4'b0101; req_addr = 16'h0705;
    step(); chk("wrap_id0", 64'(rd_id), 64'h0);
    step(); chk("wrap_id1", 64'(rd_id), 64'h2);
    step(); chk("wrap_id2", 64'(rd_id), 64'h0);

    // Stall for three cycles, then release.
    req = 4'b0010; req_addr = 16'h00C0; stall = 1'b1;
    repeat (3) step();
    chk("stall_valid", 64'(rd_valid), 64'h0);
    stall = 1'b0;
    step();
    chk("unstall_id", 64'(rd_id), 64'h1);

    // Reset the cycle after a grant to requester 3.
    req = 4'b1000; req_addr = 16'h9000;
    step();
    req = 4'b1010; reset = 1'b1;
    step();
    chk("midrst_valid", 64'(rd_valid), 64'h0);
    reset = 1'b0;
    step();
    chk("midrst_first", 64'(rd_id), 64'h1);

    // Randomized traffic with occasional stalls, resets and register updates.
    for (int c = 0; c < 400; c++) begin
      req      = NREQ'($urandom);
      req_addr = 16'($urandom);
      stall    = ($urandom_range(0, 3) == 0);
      reset    = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 15)] = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
